// File: rtl/pll_lmmi_reconfig_ctrl.sv
// Host-side controller for the PLL_CORE LMMI config port: serialises register
// reads/writes and runs the reset/relock sequence on an apply command.
module pll_lmmi_reconfig_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned RD_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_offset,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    input  logic       apply_start,
    output logic       apply_busy,
    output logic       apply_done,
    output logic       apply_fail,
    output logic       lmmi_request,
    output logic       lmmi_wr_rdn,
    output logic [6:0] lmmi_offset,
    output logic [7:0] lmmi_wdata,
    input  logic       lmmi_ready,
    input  logic [7:0] lmmi_rdata,
    input  logic       lmmi_rdata_valid,
    output logic       pll_rst,
    input  logic       pll_lock
);

    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned RD_W  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_WAIT, S_RST_HOLD, S_LOCK_WAIT, S_LOCK_CHK
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_wr, w_wr;
    logic [6:0]       r_offset, w_offset;
    logic [7:0]       r_wdata, w_wdata;
    logic [RST_W-1:0] r_rst_cnt, w_rst_cnt;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
    logic [STB_W-1:0] r_stb_cnt, w_stb_cnt;
    logic [RD_W-1:0]  r_rd_cnt, w_rd_cnt;
    logic             r_lock_meta, r_lock_sync;
    logic             r_resp_valid, w_resp_valid;
    logic [7:0]       r_resp_rdata, w_resp_rdata;
    logic             r_resp_err, w_resp_err;
    logic             r_apply_done, w_apply_done;
    logic             r_apply_fail, w_apply_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr         <= 1'b0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_rst_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_stb_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_lock_meta  <= 1'b0;
            r_lock_sync  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_apply_done <= 1'b0;
            r_apply_fail <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr         <= w_wr;
            r_offset     <= w_offset;
            r_wdata      <= w_wdata;
            r_rst_cnt    <= w_rst_cnt;
            r_tmo_cnt    <= w_tmo_cnt;
            r_stb_cnt    <= w_stb_cnt;
            r_rd_cnt     <= w_rd_cnt;
            r_lock_meta  <= pll_lock;
            r_lock_sync  <= r_lock_meta;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_apply_done <= w_apply_done;
            r_apply_fail <= w_apply_fail;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr         = r_wr;
        w_offset     = r_offset;
        w_wdata      = r_wdata;
        w_rst_cnt    = r_rst_cnt;
        w_tmo_cnt    = r_tmo_cnt;
        w_stb_cnt    = r_stb_cnt;
        w_rd_cnt     = r_rd_cnt;
        w_resp_valid = 1'b0;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = 1'b0;
        w_apply_done = 1'b0;
        w_apply_fail = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (apply_start) begin
                    w_state_nxt = S_RST_HOLD;
                    w_rst_cnt   = '0;
                end else if (req_valid) begin
                    w_wr        = req_write;
                    w_offset    = req_offset;
                    w_wdata     = req_wdata;
                    w_state_nxt = req_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (lmmi_ready) begin
                    w_resp_valid = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (lmmi_ready) begin
                    // Read data may come back in the same cycle the PLL accepts.
                    if (lmmi_rdata_valid) begin
                        w_resp_valid = 1'b1;
                        w_resp_rdata = lmmi_rdata;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_rd_cnt    = '0;
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (lmmi_rdata_valid) begin
                    w_resp_valid = 1'b1;
                    w_resp_rdata = lmmi_rdata;
                    w_state_nxt  = S_IDLE;
                end else if (r_rd_cnt >= RD_W'(RD_TIMEOUT - 1)) begin
                    w_resp_valid = 1'b1;
                    w_resp_err   = 1'b1;
                    w_resp_rdata = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_rd_cnt = r_rd_cnt + RD_W'(1);
                end
            end
            S_RST_HOLD: begin
                if (r_rst_cnt >= RST_W'(RST_CYCLES - 1)) begin
                    w_tmo_cnt   = '0;
                    w_state_nxt = S_LOCK_WAIT;
                end else begin
                    w_rst_cnt = r_rst_cnt + RST_W'(1);
                end
            end
            S_LOCK_WAIT: begin
                // Timeout budget accumulates over every visit since reset release.
                if (r_lock_sync) begin
                    w_stb_cnt   = '0;
                    w_state_nxt = S_LOCK_CHK;
                end else if (r_tmo_cnt >= TMO_W'(LOCK_TIMEOUT - 1)) begin
                    w_apply_fail = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
                end
            end
            S_LOCK_CHK: begin
                if (!r_lock_sync) begin
                    w_state_nxt = S_LOCK_WAIT;
                end else if (r_stb_cnt >= STB_W'(LOCK_STABLE - 1)) begin
                    w_apply_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_stb_cnt = r_stb_cnt + STB_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready    = (r_state == S_IDLE) && !apply_start;
    assign lmmi_request = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign lmmi_wr_rdn  = r_wr;
    assign lmmi_offset  = r_offset;
    assign lmmi_wdata   = r_wdata;
    assign pll_rst      = (r_state == S_RST_HOLD);
    assign apply_busy   = (r_state == S_RST_HOLD) || (r_state == S_LOCK_WAIT) ||
                          (r_state == S_LOCK_CHK);
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign apply_done   = r_apply_done;
    assign apply_fail   = r_apply_fail;

endmodule

// File: tb/tb_pll_lmmi_reconfig_ctrl.sv
// Scenario bench for pll_lmmi_reconfig_ctrl: tasks drive stimulus, a negedge
// monitor pops expected responses/apply outcomes from scoreboard queues.
module tb_pll_lmmi_reconfig_ctrl;

    localparam int unsigned RST_CYCLES   = 16;
    localparam int unsigned LOCK_TIMEOUT = 4096;
    localparam int unsigned LOCK_STABLE  = 64;
    localparam int unsigned RD_TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [6:0] req_offset = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, resp_valid, resp_err;
    logic [7:0] resp_rdata;
    logic       apply_start = 1'b0;
    logic       apply_busy, apply_done, apply_fail;
    logic       lmmi_request, lmmi_wr_rdn;
    logic [6:0] lmmi_offset;
    logic [7:0] lmmi_wdata;
    logic       lmmi_ready = 1'b0, lmmi_rdata_valid = 1'b0;
    logic [7:0] lmmi_rdata = '0;
    logic       pll_rst;
    logic       pll_lock = 1'b0;

    typedef struct packed {
        logic       chk;
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    resp_t q_resp[$];
    bit    q_apply[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    pll_lmmi_reconfig_ctrl #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE(LOCK_STABLE), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .apply_start(apply_start), .apply_busy(apply_busy),
        .apply_done(apply_done), .apply_fail(apply_fail),
        .lmmi_request(lmmi_request), .lmmi_wr_rdn(lmmi_wr_rdn),
        .lmmi_offset(lmmi_offset), .lmmi_wdata(lmmi_wdata),
        .lmmi_ready(lmmi_ready), .lmmi_rdata(lmmi_rdata),
        .lmmi_rdata_valid(lmmi_rdata_valid),
        .pll_rst(pll_rst), .pll_lock(pll_lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            n_cmp++;
            if (q_resp.size() == 0) begin
                $display("FAIL resp_unexpected: got resp err=%b rdata=%h, want none", resp_err, resp_rdata);
                n_bad++;
            end else begin
                resp_t e;
                e = q_resp.pop_front();
                if (resp_err !== e.err || (e.chk && resp_rdata !== e.rdata)) begin
                    $display("FAIL resp_data: got err=%b rdata=%h, want err=%b rdata=%h",
                             resp_err, resp_rdata, e.err, e.rdata);
                    n_bad++;
                end
            end
        end
        if (apply_done === 1'b1 || apply_fail === 1'b1) begin
            n_cmp++;
            if (q_apply.size() == 0) begin
                $display("FAIL apply_unexpected: got done=%b fail=%b, want none", apply_done, apply_fail);
                n_bad++;
            end else begin
                bit e;
                e = q_apply.pop_front();
                if ({apply_done, apply_fail} !== (e ? 2'b10 : 2'b01)) begin
                    $display("FAIL apply_outcome: got done=%b fail=%b, want done=%b", apply_done, apply_fail, e);
                    n_bad++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        if ({req_ready, resp_valid, resp_err, apply_busy, apply_done, apply_fail, lmmi_request, pll_rst} !== 8'b1000_0000) begin
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {req_ready, resp_valid, resp_err, apply_busy, apply_done, apply_fail, lmmi_request, pll_rst});
            n_bad++;
        end
        n_cmp++;
        if ({resp_rdata, lmmi_wr_rdn, lmmi_offset, lmmi_wdata} !== 24'h0) begin
            $display("FAIL reset_data: got %h want 000000", {resp_rdata, lmmi_wr_rdn, lmmi_offset, lmmi_wdata});
            n_bad++;
        end
        n_cmp++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int n_req = 0;
        req_valid = 1'b1; req_write = 1'b1; req_offset = 7'h11; req_wdata = 8'h2A;
        #1;
        if (req_ready !== 1'b1) begin
            $display("FAIL wr_ready: got %b want 1", req_ready); n_bad++;
        end
        n_cmp++;
        q_resp.push_back('{chk: 1'b0, rdata: 8'h00, err: 1'b0});
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lmmi_ready = (i == 2);
            #1;
            if (lmmi_request === 1'b1) n_req++;
            if ({lmmi_wr_rdn, lmmi_offset, lmmi_wdata, req_ready} !== {1'b1, 7'h11, 8'h2A, 1'b0}) begin
                $display("FAIL wr_fields: got wr=%b off=%h data=%h rdy=%b want 1/11/2a/0",
                         lmmi_wr_rdn, lmmi_offset, lmmi_wdata, req_ready);
                n_bad++;
            end
            n_cmp++;
            tick();
        end
        lmmi_ready = 1'b0;
        #1;
        if (n_req != 3) begin
            $display("FAIL wr_req_cycles: got %0d want 3", n_req); n_bad++;
        end
        n_cmp++;
        if ({lmmi_request, resp_valid, req_ready} !== 3'b011) begin
            $display("FAIL wr_complete: got req/resp/rdy=%b want 011", {lmmi_request, resp_valid, req_ready});
            n_bad++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_read();
        req_valid = 1'b1; req_write = 1'b0; req_offset = 7'h05;
        q_resp.push_back('{chk: 1'b1, rdata: 8'hC3, err: 1'b0});
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1;
        #1;
        if ({lmmi_request, lmmi_wr_rdn, lmmi_offset} !== {1'b1, 1'b0, 7'h05}) begin
            $display("FAIL rd_fields: got req=%b wr=%b off=%h want 1/0/05", lmmi_request, lmmi_wr_rdn, lmmi_offset);
            n_bad++;
        end
        n_cmp++;
        tick();
        lmmi_ready = 1'b0;
        tick();
        lmmi_rdata_valid = 1'b1; lmmi_rdata = 8'hC3;
        tick();
        lmmi_rdata_valid = 1'b0; lmmi_rdata = 8'h00;
        #1;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 8'hC3}) begin
            $display("FAIL rd_resp: got v=%b e=%b d=%h want 1/0/c3", resp_valid, resp_err, resp_rdata);
            n_bad++;
        end
        n_cmp++;
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_offset = 7'h7F;
        q_resp.push_back('{chk: 1'b1, rdata: 8'h5A, err: 1'b0});
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1; lmmi_rdata_valid = 1'b1; lmmi_rdata = 8'h5A;
        tick();
        lmmi_ready = 1'b0; lmmi_rdata_valid = 1'b0; lmmi_rdata = 8'h00;
        #1;
        if (resp_valid !== 1'b1) begin
            $display("FAIL rd_same_cycle: got resp_valid=%b want 1", resp_valid); n_bad++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_rd_timeout();
        int n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_offset = 7'h33;
        q_resp.push_back('{chk: 1'b1, rdata: 8'h00, err: 1'b1});
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1;
        tick();
        lmmi_ready = 1'b0;
        while (resp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (n < RD_TIMEOUT || n > RD_TIMEOUT + 2) begin
            $display("FAIL rd_timeout_latency: got %0d cycles want %0d..%0d", n, RD_TIMEOUT, RD_TIMEOUT + 2);
            n_bad++;
        end
        n_cmp++;
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_offset = 7'h01; req_wdata = 8'hE7;
        #1;
        if (req_ready !== 1'b1) begin
            $display("FAIL rd_timeout_next_ready: got %b want 1", req_ready); n_bad++;
        end
        n_cmp++;
        q_resp.push_back('{chk: 1'b0, rdata: 8'h00, err: 1'b0});
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1;
        tick();
        lmmi_ready = 1'b0;
        tick();
    endtask

    task automatic test_apply_lock();
        int cnt = 0;
        int n = 0;
        apply_start = 1'b1;
        q_apply.push_back(1'b1);
        tick();
        apply_start = 1'b0;
        while (pll_rst === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        if (cnt != RST_CYCLES) begin
            $display("FAIL apply_rst_width: got %0d want %0d", cnt, RST_CYCLES); n_bad++;
        end
        n_cmp++;
        if ({apply_busy, req_ready, pll_rst} !== 3'b100) begin
            $display("FAIL apply_lock_wait: got busy/rdy/rst=%b want 100", {apply_busy, req_ready, pll_rst});
            n_bad++;
        end
        n_cmp++;
        repeat (100) begin
            tick();
            n++;
        end
        pll_lock = 1'b1;
        while (apply_done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (n < 165 || n > 167) begin
            $display("FAIL apply_done_latency: got %0d want 165..167", n); n_bad++;
        end
        n_cmp++;
        tick();
        if (apply_busy !== 1'b0) begin
            $display("FAIL apply_busy_clear: got %b want 0", apply_busy); n_bad++;
        end
        n_cmp++;
        pll_lock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_lock_glitch();
        int n = 0;
        int g = 0;
        apply_start = 1'b1;
        q_apply.push_back(1'b1);
        tick();
        apply_start = 1'b0;
        while (pll_rst === 1'b1 && g < 100) begin
            g++;
            tick();
        end
        pll_lock = 1'b1;
        repeat (33) begin
            tick();
            n++;
        end
        pll_lock = 1'b0;
        tick();
        n++;
        pll_lock = 1'b1;
        while (apply_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (n < 97 || n > 105) begin
            $display("FAIL glitch_done_latency: got %0d want 97..105", n); n_bad++;
        end
        n_cmp++;
        pll_lock = 1'b0;
        repeat (3) tick();
        n = 0; g = 0;
        apply_start = 1'b1;
        q_apply.push_back(1'b0);
        tick();
        apply_start = 1'b0;
        while (pll_rst === 1'b1 && g < 100) begin
            g++;
            tick();
        end
        while (apply_fail !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        if (n < LOCK_TIMEOUT - 1 || n > LOCK_TIMEOUT + 1) begin
            $display("FAIL lock_timeout_latency: got %0d want %0d..%0d", n, LOCK_TIMEOUT - 1, LOCK_TIMEOUT + 1);
            n_bad++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_apply_vs_req();
        int n = 0;
        apply_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_offset = 7'h22; req_wdata = 8'h99;
        #1;
        if (req_ready !== 1'b0) begin
            $display("FAIL collide_ready: got %b want 0", req_ready); n_bad++;
        end
        n_cmp++;
        q_apply.push_back(1'b1);
        q_resp.push_back('{chk: 1'b0, rdata: 8'h00, err: 1'b0});
        tick();
        apply_start = 1'b0;
        if ({apply_busy, pll_rst, lmmi_request} !== 3'b110) begin
            $display("FAIL collide_apply_wins: got busy/rst/req=%b want 110", {apply_busy, pll_rst, lmmi_request});
            n_bad++;
        end
        n_cmp++;
        pll_lock = 1'b1;
        while (apply_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if ({apply_busy, req_ready} !== 2'b01) begin
            $display("FAIL collide_apply_end: got busy/rdy=%b after %0d cycles want 01", {apply_busy, req_ready}, n);
            n_bad++;
        end
        n_cmp++;
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1;
        #1;
        if ({lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata} !== {1'b1, 1'b1, 7'h22, 8'h99}) begin
            $display("FAIL collide_pending_req: got req=%b wr=%b off=%h data=%h want 1/1/22/99",
                     lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata);
            n_bad++;
        end
        n_cmp++;
        tick();
        lmmi_ready = 1'b0;
        pll_lock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_rst_mid();
        req_valid = 1'b1; req_write = 1'b0; req_offset = 7'h44;
        tick();
        req_valid = 1'b0; lmmi_ready = 1'b1;
        tick();
        lmmi_ready = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({req_ready, lmmi_request, resp_valid} !== 3'b100) begin
            $display("FAIL rst_rd_wait: got rdy/req/resp=%b want 100", {req_ready, lmmi_request, resp_valid});
            n_bad++;
        end
        n_cmp++;
        repeat (300) tick();
        apply_start = 1'b1;
        tick();
        apply_start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({pll_rst, apply_busy, req_ready} !== 3'b001) begin
            $display("FAIL rst_rst_hold: got rst/busy/rdy=%b want 001", {pll_rst, apply_busy, req_ready});
            n_bad++;
        end
        n_cmp++;
        repeat (50) tick();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 8; t++) begin
            logic       w;
            logic [7:0] d;
            int         rdy_lat;
            int         rd_lat;
            w       = 1'($urandom_range(0, 1));
            d       = 8'($urandom_range(0, 255));
            rdy_lat = $urandom_range(0, 2);
            rd_lat  = $urandom_range(0, 3);
            req_valid = 1'b1; req_write = w; req_offset = 7'($urandom_range(0, 127)); req_wdata = d;
            q_resp.push_back('{chk: !w, rdata: d, err: 1'b0});
            tick();
            req_valid = 1'b0;
            repeat (rdy_lat) tick();
            lmmi_ready = 1'b1;
            if (!w && rd_lat == 0) begin
                lmmi_rdata_valid = 1'b1; lmmi_rdata = d;
            end
            tick();
            lmmi_ready = 1'b0; lmmi_rdata_valid = 1'b0;
            if (!w && rd_lat > 0) begin
                repeat (rd_lat - 1) tick();
                lmmi_rdata_valid = 1'b1; lmmi_rdata = d;
                tick();
                lmmi_rdata_valid = 1'b0;
            end
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rd_timeout();
        test_apply_lock();
        test_lock_glitch();
        test_apply_vs_req();
        test_rst_mid();
        test_back_to_back();
        if (q_resp.size() != 0 || q_apply.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d resp / %0d apply pending want 0/0", q_resp.size(), q_apply.size());
            n_bad++;
        end
        n_cmp++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
